// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states, word geometry.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package lsu_pkg;

    localparam int WORD_BYTES = 4;

    // req_op = {is_store, funct3}
    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_STORE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == OP_LB)  || (op == OP_LH)  || (op == OP_LW)  ||
               (op == OP_LBU) || (op == OP_LHU) || (op == OP_SB)  ||
               (op == OP_SH)  || (op == OP_SW);
    endfunction

    // Halfwords need an even address, words need a 4-byte-aligned address.
    function automatic logic op_is_misaligned(input logic [3:0] op, input logic [1:0] lane);
        return ((op[1:0] == 2'b01) && lane[0]) ||
               ((op[1:0] == 2'b10) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract + sign/zero extend for loads, lane merge for sub-word stores.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//   i_funct3    : size in [1:0] (00 byte, 01 half, 10 word), [2]=1 for zero-extend
//   i_lane      : byte offset within the word (little-endian)
//   i_rd_word   : word read from memory
//   i_wdata     : right-aligned store data (only the low halfword is ever merged)
//   o_load_data : extended load result
//   o_merged    : memory word with the store byte/half inserted into its lane
module lsu_align (
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rd_word,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);
    import lsu_pkg::*;

    logic [4:0]  w_sh_byte;
    logic [4:0]  w_sh_half;
    logic [31:0] w_byte_word;
    logic [31:0] w_half_word;
    logic [31:0] w_mask;

    assign w_sh_byte   = {i_lane, 3'b000};
    assign w_sh_half   = {i_lane[1], 4'b0000};
    assign w_byte_word = i_rd_word >> w_sh_byte;
    assign w_half_word = i_rd_word >> w_sh_half;

    always_comb begin
        o_load_data = i_rd_word;
        case (i_funct3[1:0])
            2'b00:   o_load_data = i_funct3[2] ? {24'd0, w_byte_word[7:0]}
                                               : {{24{w_byte_word[7]}}, w_byte_word[7:0]};
            2'b01:   o_load_data = i_funct3[2] ? {16'd0, w_half_word[15:0]}
                                               : {{16{w_half_word[15]}}, w_half_word[15:0]};
            default: o_load_data = i_rd_word;
        endcase
    end

    always_comb begin
        w_mask   = 32'd0;
        o_merged = i_rd_word;
        case (i_funct3[1:0])
            2'b00: begin
                w_mask   = 32'h0000_00FF << w_sh_byte;
                o_merged = (i_rd_word & ~w_mask) | ({24'd0, i_wdata[7:0]} << w_sh_byte);
            end
            2'b01: begin
                w_mask   = 32'h0000_FFFF << w_sh_half;
                o_merged = (i_rd_word & ~w_mask) | ({16'd0, i_wdata} << w_sh_half);
            end
            default: o_merged = i_rd_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Core-side load/store initiator driving a combinational-read Data_Memory (WE/A/WD/RD).
// Latency: accept->resp_valid = 2 cycles load/SW, 3 cycles SB/SH (read-modify-write), 1 cycle error.
// Backpressure: one request in flight; req_ready only in IDLE, response held until resp_ready.
// Optional: define LSU_BOUNDS_CHECK_EN to fault word indices >= MEM_DEPTH without touching memory.
// Ports: clk/rst (async active-low); req_valid/req_ready/req_op/req_addr/req_wdata core request;
//        resp_valid/resp_ready/resp_rdata/resp_err core response; mem_we/mem_a/mem_wd/mem_rd memory.
module load_store_unit #(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [31:0]       mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);
    import lsu_pkg::*;

`ifdef LSU_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    lsu_state_t        r_state;
    lsu_state_t        w_next_state;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic [31:0]       r_word;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_req_bad;
    logic              w_out_of_range;
    logic [ADDR_W-1:0] w_req_idx;
    logic [ADDR_W-1:0] w_word_idx;
    logic              w_mem_active;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;

    // Gating with rst keeps req_ready low for the whole reset assertion.
    assign req_ready = (r_state == ST_IDLE) && rst;
    assign w_accept  = req_valid && req_ready;

    assign w_req_idx      = req_addr >> 2;
    assign w_out_of_range = (w_req_idx >= ADDR_W'(MEM_DEPTH));
    assign w_req_bad      = !op_is_legal(req_op) ||
                            op_is_misaligned(req_op, req_addr[1:0]) ||
                            (BOUNDS_EN && w_out_of_range);

    // All memory outputs decode from r_state, so an async reset drops mem_we immediately.
    assign w_word_idx   = r_addr >> 2;
    assign w_mem_active = (r_state == ST_LOAD) || (r_state == ST_RMW_RD) || (r_state == ST_STORE);
    assign mem_we       = (r_state == ST_STORE);
    assign mem_a        = w_mem_active ? 32'(w_word_idx) : 32'd0;
    assign mem_wd       = mem_we ? r_word : 32'd0;

    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    lsu_align u_align (
        .i_funct3    (r_funct3),
        .i_lane      (r_addr[1:0]),
        .i_rd_word   (mem_rd),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_bad)         w_next_state = ST_RESP;
                    else if (!req_op[3])   w_next_state = ST_LOAD;
                    else if (req_op == OP_SW) w_next_state = ST_STORE;
                    else                   w_next_state = ST_RMW_RD;
                end
            end
            ST_LOAD:   w_next_state = ST_RESP;
            ST_RMW_RD: w_next_state = ST_STORE;
            ST_STORE:  w_next_state = ST_RESP;
            ST_RESP:   if (resp_ready) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 16'd0;
            r_word   <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= req_op[2:0];
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata[15:0];
                        // SW skips the read phase, so the store word is known now.
                        r_word   <= req_wdata;
                        r_rdata  <= 32'd0;
                        r_err    <= w_req_bad;
                    end
                end
                ST_LOAD:   r_rdata <= w_load_data;
                ST_RMW_RD: r_word  <= w_merged;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    // Data memory: 1024 words, combinational read, synchronous write.
    logic [31:0] dmem [0:1023];
    assign mem_rd = (mem_a < 32'd1024) ? dmem[mem_a[9:0]] : 32'd0;
    always @(posedge clk) begin
        if (mem_we && (mem_a < 32'd1024)) dmem[mem_a[9:0]] <= mem_wd;
    end

    int          we_cnt = 0;
    logic [31:0] last_a = 32'd0;
    logic [31:0] last_wd = 32'd0;
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt  <= we_cnt + 1;
            last_a  <= mem_a;
            last_wd <= mem_wd;
        end
    end

    always #5 clk = ~clk;

    load_store_unit #(.MEM_DEPTH(1024), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input int exp_we, input logic [31:0] exp_a, input logic [31:0] exp_wd,
                        input int hold);
        exp_t        e;
        int          cyc;
        int          we0;
        logic [31:0] held;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sb.push_back(e);
        resp_ready = (hold == 0);
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        we0       = we_cnt;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!resp_valid && cyc < 8);
        e = sb.pop_front();
        chk("latency", 32'(cyc), 32'(e.lat));
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
        if (hold > 0) begin
            held = resp_rdata;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", {31'd0, resp_valid}, 32'd1);
                chk("hold_rdata", resp_rdata, held);
                chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
                chk("hold_mem_quiet", {mem_we, mem_a[30:0]} | mem_wd, 32'd0);
            end
            resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("resp_done", {31'd0, resp_valid}, 32'd0);
        chk("back_to_idle", {31'd0, req_ready}, 32'd1);
        chk("we_pulses", 32'(we_cnt - we0), 32'(exp_we));
        if (exp_we > 0) begin
            chk("store_mem_a", last_a, exp_a);
            chk("store_mem_wd", last_wd, exp_wd);
        end
    endtask

    initial begin
        int we0;
        for (int i = 0; i < 1024; i++) dmem[i] = 32'd0;

        // Reset state
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        //   op      addr        wdata         exp_rd        err  lat we  mem_a  mem_wd        hold
        send(OP_SW,  32'h28, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'd10, 32'hDEADBEEF, 0);
        send(OP_LB,  32'h2B, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 0, 32'd0,  32'h0,        0);
        send(OP_LBU, 32'h2B, 32'h0,        32'h000000DE, 1'b0, 2, 0, 32'd0,  32'h0,        0);
        send(OP_LH,  32'h28, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 0, 32'd0,  32'h0,        0);
        send(OP_SH,  32'h2A, 32'h00001234, 32'h0,        1'b0, 3, 1, 32'd10, 32'h1234BEEF, 0);
        send(OP_LW,  32'h28, 32'h0,        32'h1234BEEF, 1'b0, 2, 0, 32'd0,  32'h0,        0);
        send(OP_LW,  32'h29, 32'h0,        32'h0,        1'b1, 1, 0, 32'd0,  32'h0,        0);
        send(OP_SH,  32'h2B, 32'h5555,     32'h0,        1'b1, 1, 0, 32'd0,  32'h0,        0);
        send(4'b0011, 32'h28, 32'h0,       32'h0,        1'b1, 1, 0, 32'd0,  32'h0,        0);
        send(OP_LHU, 32'h2A, 32'h0,        32'h00001234, 1'b0, 2, 0, 32'd0,  32'h0,        5);
        send(OP_SB,  32'h29, 32'hFFFFFFA5, 32'h0,        1'b0, 3, 1, 32'd10, 32'h1234A5EF, 0);
        send(OP_LW,  32'h28, 32'h0,        32'h1234A5EF, 1'b0, 2, 0, 32'd0,  32'h0,        0);
        send(OP_LH,  32'h2A, 32'h0,        32'h00001234, 1'b0, 2, 0, 32'd0,  32'h0,        0);

        // Reset while the SB read phase is in progress.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_SB;
        req_addr  = 32'h28;
        req_wdata = 32'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        we0 = we_cnt;
        chk("abort_in_rmw_rd", mem_a, 32'd10);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_mem_a", mem_a, 32'd0);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_idle", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("abort_no_we", 32'(we_cnt - we0), 32'd0);
        chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        send(OP_LW,  32'h28, 32'h0,        32'h1234A5EF, 1'b0, 2, 0, 32'd0,  32'h0,        0);

`ifdef LSU_BOUNDS_CHECK_EN
        send(OP_LW,  32'h1000, 32'h0,      32'h0,        1'b1, 1, 0, 32'd0,  32'h0,        0);
        send(OP_SW,  32'h1000, 32'h1,      32'h0,        1'b1, 1, 0, 32'd0,  32'h0,        0);
`else
        send(OP_SW,  32'hFFC, 32'hCAFEF00D, 32'h0,       1'b0, 2, 1, 32'd1023, 32'hCAFEF00D, 0);
        send(OP_LW,  32'hFFC, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0, 32'd0,   32'h0,        0);
`endif

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port: turns core load/store requests into Data_Memory accesses.
- Drives WE/A/WD to Data_Memory and consumes its combinational RD.
- Handles byte/halfword loads with sign/zero extension; sub-word stores via read-modify-write.
- Sits between the execute stage and Data_Memory; valid/ready on both core-facing channels.

Parameters:
- MEM_DEPTH, 1024, Data_Memory depth in 32-bit words.
- ADDR_W, 32, core byte-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  LSU can accept a request.
- req_op  in  4  {is_store, funct3}; encodings in lsu_pkg.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned/illegal/out-of-range access.
- mem_we  out  1  to Data_Memory WE.
- mem_a  out  32  to Data_Memory A; word index = addr[31:2], zero-extended.
- mem_wd  out  32  to Data_Memory WD.
- mem_rd  in  32  from Data_Memory RD; combinational read.

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_we, mem_a, mem_wd, resp_valid, resp_rdata, resp_err all 0; req_ready=0 while rst=0.
- States: IDLE, LOAD, RMW_RD, STORE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch op/addr/wdata:
  - Illegal op or misaligned access goes to RESP with err=1. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Load goes to LOAD; SW goes to STORE; SB/SH go to RMW_RD.
- LOAD: mem_a=word index, mem_we=0. Capture mem_rd, select lane by addr[1:0] (little-endian), sign- or zero-extend, then RESP.
- RMW_RD: mem_a=word index, mem_we=0. Capture mem_rd, merge the byte/half of wdata into its lane, then STORE.
- STORE: mem_we=1 for exactly this one cycle, mem_a=word index, mem_wd=merged word, then RESP.
- RESP: resp_valid=1; rdata/err held stable until resp_ready=1, then IDLE. req_ready=0 throughout.
- Latency from the accept edge to resp_valid: load/SW 2 cycles; SB/SH 3 cycles; error 1 cycle.
- Throughput: one request in flight; no new accept in the same cycle as response handshake.
- Erroring requests never assert mem_we.
- Reset mid-operation: abort immediately, mem_we drops asynchronously, no partial write, pending response discarded.
- mem_a/mem_wd are 0 in IDLE and RESP.

Optional Feature:
- Macro LSU_BOUNDS_CHECK_EN.
- Defined: word index >= MEM_DEPTH is treated like misaligned (err=1, 1-cycle response, no memory access).
- Undefined: no range check; the address is passed through and out-of-range behaviour is Data_Memory's.

Decomposition:
- lsu_pkg holds:
  - op encodings: LB=0000, LH=0001, LW=0010, LBU=0100, LHU=0101, SB=1000, SH=1001, SW=1010;
  - state encoding;
  - WORD_BYTES=4.
- Sub-module lsu_align (combinational): lane extract + extend for loads, lane merge for stores. Shared by LOAD and RMW_RD paths.

Test Plan:
- Bench connects to a real Data_Memory instance.
- SW addr 0x28 data 0xDEADBEEF -> single mem_we pulse with mem_a=10, mem_wd=0xDEADBEEF; resp_valid 2 cycles after accept, err=0.
- LB addr 0x2B -> resp_rdata 0xFFFFFFDE; LBU addr 0x2B -> 0x000000DE; LH addr 0x28 -> 0xFFFFBEEF.
- SH addr 0x2A data 0x00001234 -> RMW read then mem_wd=0x1234BEEF; following LW 0x28 -> 0x1234BEEF.
- LW addr 0x29, SH addr 0x2B -> err=1, 1-cycle response, mem_we never asserted; with LSU_BOUNDS_CHECK_EN, LW addr 0x1000 -> err=1.
- resp_ready held 0 for 5 cycles -> resp_valid/rdata stable, req_ready=0, no memory activity.
- rst pulled low during RMW_RD of SB addr 0x28 -> mem_we never pulses, state IDLE after release, later LW 0x28 returns the unchanged word.
